// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the registered carry-lookahead adder self-test slice.
//   CLA_WIDTH   : default operand width of the adder under test
//   CLA_VEC_W   : width of one stimulus vector {cin, y, x}
//   chk_state_t : sweep controller states
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH = 4;
    localparam int CLA_VEC_W = 2 * CLA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/cla_chk_delay.sv
// -----------------------------------------------------------------------------
// cla_chk_delay
// Depth-N valid+data shift register used to line up expected results with
// the adder's pipelined outputs. DEPTH = 0 degenerates to a wire.
// Ports:
//   clk       in   clock, rising edge
//   res       in   synchronous active-high reset
//   clr       in   synchronous flush of all stages (valid and data)
//   in_valid  in   valid bit entering stage 0
//   in_data   in   DW-bit payload entering stage 0
//   out_valid out  valid bit at the DEPTH tap
//   out_data  out  payload at the DEPTH tap
// -----------------------------------------------------------------------------
module cla_chk_delay #(
    parameter int DEPTH = 1,
    parameter int DW    = 1
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_sr
            logic          v_q [DEPTH];
            logic [DW-1:0] d_q [DEPTH];

            always_ff @(posedge clk) begin
                if (res || clr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        v_q[i] <= 1'b0;
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= in_valid;
                    d_q[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign out_valid = v_q[DEPTH-1];
            assign out_data  = d_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cla_stim_checker.sv
// -----------------------------------------------------------------------------
// cla_stim_checker
// Exhaustive stimulus generator and result checker for a registered
// carry-lookahead adder. Drives every {cin, y, x} combination once, compares
// the returned z/cout against a locally computed sum delayed to match the
// adder pipeline, and reports pass/fail, an error count and the first
// failing vector.
// Ports:
//   clk, res         clock and synchronous active-high reset
//   start            one-cycle pulse, starts a sweep from IDLE or DONE
//   x, y, cin        registered operands driven to the adder
//   z, cout          result returned by the adder
//   busy             high while sweeping or draining
//   done             high once a sweep has finished, until start/res
//   pass             high with done when no mismatch was seen
//   err_cnt          saturating count of mismatching vectors
//   first_err        {cin, y, x} of the first mismatch, 0 if none
// Build option:
//   CLA_CHK_STOP_ON_ERR_EN  end the sweep at the first mismatch and discard
//                           all vectors still in flight.
// Handshake: there is none; z is trusted Z_LAT cycles and cout C_LAT cycles
// after the operands appear on x/y/cin, one vector per cycle.
// -----------------------------------------------------------------------------
module cla_stim_checker
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int Z_LAT = 2,
    parameter int C_LAT = 1,
    parameter int ERR_W = 16
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    output logic [WIDTH-1:0]   x,
    output logic [WIDTH-1:0]   y,
    output logic               cin,
    input  logic [WIDTH-1:0]   z,
    input  logic               cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [2*WIDTH:0]   first_err
);

    localparam int          VEC_W      = 2 * WIDTH + 1;
    localparam logic [3:0]  DRAIN_LAST = 4'(Z_LAT - 1);

    chk_state_t        state;
    logic [VEC_W-1:0]  vec;
    logic [3:0]        drain_cnt;
    logic              issue_v;
    logic [WIDTH:0]    sum;

    logic              zt_v;
    logic [VEC_W-1:0]  zt_vec;
    logic [WIDTH-1:0]  zt_exp;
    logic              ct_v;
    logic              ct_exp;
    logic              c_bad;
    logic              fl_v;
    logic              fl_bad;
    logic              vec_err;
    logic              flush;

    // The operand registers already hold the vector of the current RUN
    // cycle, so the expected sum is formed from them directly.
    assign issue_v = (state == RUN);
    assign sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

    cla_chk_delay #(.DEPTH(Z_LAT), .DW(VEC_W + WIDTH)) u_z_line (
        .clk       (clk),
        .res       (res),
        .clr       (flush),
        .in_valid  (issue_v),
        .in_data   ({cin, y, x, sum[WIDTH-1:0]}),
        .out_valid (zt_v),
        .out_data  ({zt_vec, zt_exp})
    );

    cla_chk_delay #(.DEPTH(C_LAT), .DW(1)) u_c_line (
        .clk       (clk),
        .res       (res),
        .clr       (flush),
        .in_valid  (issue_v),
        .in_data   (sum[WIDTH]),
        .out_valid (ct_v),
        .out_data  (ct_exp)
    );

    // cout is judged earlier than z; its verdict rides along for the
    // remaining stages so a vector is scored exactly once, at its z tap.
    assign c_bad = ct_v && (cout != ct_exp);

    cla_chk_delay #(.DEPTH(Z_LAT - C_LAT), .DW(1)) u_c_flag (
        .clk       (clk),
        .res       (res),
        .clr       (flush),
        .in_valid  (ct_v),
        .in_data   (c_bad),
        .out_valid (fl_v),
        .out_data  (fl_bad)
    );

    assign vec_err = zt_v && ((z != zt_exp) || (fl_v && fl_bad));

`ifdef CLA_CHK_STOP_ON_ERR_EN
    assign flush = busy && vec_err;
`else
    assign flush = 1'b0;
`endif

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            vec       <= '0;
            drain_cnt <= '0;
            x         <= '0;
            y         <= '0;
            cin       <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        vec         <= '0;
                        {cin, y, x} <= '0;
                        err_cnt     <= '0;
                        first_err   <= '0;
                    end
                end
                RUN: begin
                    // Operands track vec, so the cycle showing all-ones is
                    // the last issue cycle; vec never wraps.
                    if (vec == {VEC_W{1'b1}}) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        vec         <= vec + VEC_W'(1);
                        {cin, y, x} <= vec + VEC_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (busy && vec_err) begin
                if (err_cnt == '0) begin
                    first_err <= zt_vec;
                end
                if (err_cnt != {ERR_W{1'b1}}) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
`ifdef CLA_CHK_STOP_ON_ERR_EN
                state <= DONE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_cla_stim_checker
// Bench for cla_stim_checker: a registered 4-bit adder model with selectable
// faults sits on the far side of the operand/result interface. Each sweep's
// expected outcome is pushed to exp_q when start is issued; a monitor pops it
// when done rises and compares.
// -----------------------------------------------------------------------------
module tb_cla_stim_checker;

    localparam int WIDTH = 4;
    localparam int Z_LAT = 2;
    localparam int C_LAT = 1;
    localparam int ERR_W = 16;
    localparam int NVEC  = 512;
    localparam int EW    = 47;

    logic              clk = 1'b0;
    logic              res;
    logic              start;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              cin;
    logic [WIDTH-1:0]  z;
    logic              cout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [2*WIDTH:0]  first_err;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    int fault_mode = 0;
    int fault_vec  = 0;

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    cla_stim_checker #(
        .WIDTH (WIDTH),
        .Z_LAT (Z_LAT),
        .C_LAT (C_LAT),
        .ERR_W (ERR_W)
    ) dut (
        .clk       (clk),
        .res       (res),
        .start     (start),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .z         (z),
        .cout      (cout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    // ------------------------------------------------------------ adder model
    // Input flop then output flop for z; cout straight off the input flop.
    // fault_mode: 0 none, 1 z[1] stuck 0, 2 cout stuck 0, 3 z[0] stuck 0,
    //             4 z[0] inverted for the single vector fault_vec.
    logic [3:0] xr = '0;
    logic [3:0] yr = '0;
    logic       cr = 1'b0;
    logic [3:0] zr = '0;

    function automatic logic [3:0] adder_z(input logic [3:0] a, input logic [3:0] b,
                                           input logic c);
        logic [4:0] s;
        logic [3:0] r;
        s = {1'b0, a} + {1'b0, b} + {4'b0, c};
        r = s[3:0];
        if (fault_mode == 1) r[1] = 1'b0;
        if (fault_mode == 3) r[0] = 1'b0;
        if (fault_mode == 4 && {c, b, a} == 9'(fault_vec)) r[0] = ~r[0];
        return r;
    endfunction

    always @(posedge clk) begin
        xr <= x;
        yr <= y;
        cr <= cin;
        zr <= adder_z(xr, yr, cr);
    end

    assign z = zr;
    always_comb begin
        cout = (({1'b0, xr} + {1'b0, yr} + {4'b0, cr}) >= 5'd16);
        if (fault_mode == 2) cout = 1'b0;
    end

    // ------------------------------------------------------------ reference
    // Outcome of a whole sweep from the adder's fault rules, expressed on the
    // arithmetic sum. Packed as {visits, busy_cycles, pass, err_cnt, first}.
    function automatic logic [EW-1:0] model_sweep(input int mode, input int k);
        int cnt;
        int first;
        int s;
        int exp_err;
        int exp_busy;
        int exp_visits;
        logic bad;
        logic [8:0]  f9;
        cnt   = 0;
        first = -1;
        for (int v = 0; v < NVEC; v++) begin
            s = (v & 15) + ((v >> 4) & 15) + ((v >> 8) & 1);
            case (mode)
                1: bad = ((s >> 1) & 1) == 1;
                2: bad = s >= 16;
                3: bad = (s & 1) == 1;
                4: bad = (v == k);
                default: bad = 1'b0;
            endcase
            if (bad) begin
                if (first < 0) first = v;
                cnt++;
            end
        end
`ifdef CLA_CHK_STOP_ON_ERR_EN
        exp_err    = (cnt > 0) ? 1 : 0;
        exp_busy   = (first >= 0) ? first + Z_LAT + 1 : NVEC + Z_LAT;
        exp_visits = (exp_busy < NVEC) ? exp_busy : NVEC;
`else
        exp_err    = cnt;
        exp_busy   = NVEC + Z_LAT;
        exp_visits = NVEC;
`endif
        f9 = (first >= 0) ? 9'(first) : 9'd0;
        return {10'(exp_visits), 11'(exp_busy), (cnt == 0), 16'(exp_err), f9};
    endfunction

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: counts busy cycles and in-order vector visits, scores each
    // finished sweep against the oldest queued expectation.
    int         busy_cnt = 0;
    int         next_vec = 0;
    logic       done_d   = 1'b0;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (res) begin
            busy_cnt = 0;
            next_vec = 0;
            done_d   = 1'b0;
        end else begin
            if (busy) begin
                if (next_vec < NVEC && {cin, y, x} == 9'(next_vec)) next_vec++;
                busy_cnt++;
            end
            if (done && !done_d) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_cnt",     64'(err_cnt),   64'(e[24:9]));
                    check("first_err",   64'(first_err), 64'(e[8:0]));
                    check("pass",        64'(pass),      64'(e[25]));
                    check("busy_cycles", 64'(busy_cnt),  64'(e[36:26]));
                    check("vec_order",   64'(next_vec),  64'(e[46:37]));
                end
                busy_cnt = 0;
                next_vec = 0;
            end
            done_d = done;
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_in_time", 64'(done), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},         64'(x),         0);
        check({tag, "_y"},         64'(y),         0);
        check({tag, "_cin"},       64'(cin),       0);
        check({tag, "_busy"},      64'(busy),      0);
        check({tag, "_done"},      64'(done),      0);
        check({tag, "_pass"},      64'(pass),      0);
        check({tag, "_err_cnt"},   64'(err_cnt),   0);
        check({tag, "_first_err"}, 64'(first_err), 0);
    endtask

    // ------------------------------------------------------------ stimulus
    int modes[6] = '{0, 1, 2, 3, 4, 4};

    initial begin
        int n;
        res   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        res = 1'b0;

        // Sweeps against each adder fault; the first also gets a start pulse
        // mid-RUN, which must not disturb it.
        for (int i = 0; i < 6; i++) begin
            fault_mode = modes[i];
            fault_vec  = $urandom_range(0, NVEC - 1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            exp_q.push_back(model_sweep(fault_mode, fault_vec));
            pulse_start();
            if (i == 0) begin
                repeat ($urandom_range(10, 300)) @(negedge clk);
                pulse_start();
                check("busy_after_ignored_start", 64'(busy), 64'd1);
            end
            wait_done(2000);
        end

        // Restart out of DONE after a failing sweep clears the result.
        fault_mode = 0;
        exp_q.push_back(model_sweep(0, 0));
        pulse_start();
        check("restart_err_cleared", 64'(err_cnt),   0);
        check("restart_first_clr",   64'(first_err), 0);
        check("restart_done_low",    64'(done),      0);
        check("restart_busy",        64'(busy),      1);
        wait_done(2000);

        // Reset in the middle of a sweep, at vector 100.
        fault_mode = 1;
        exp_q.push_back(model_sweep(1, 0));
        pulse_start();
        n = 0;
        while ({cin, y, x} != 9'd100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_vec_100", 64'({cin, y, x}), 64'd100);
        res = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        @(negedge clk);
        res = 1'b0;
        void'(exp_q.pop_back());

        // Clean sweep after the abort.
        fault_mode = 0;
        exp_q.push_back(model_sweep(0, 0));
        pulse_start();
        wait_done(2000);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
